// File: rtl/prbs5_checker.sv
// Serial PRBS-5 (x^5+x^3+1) checker: self-syncs to the generator stream, flags bit errors once locked.
// Optional saturating error counter and cnt_clr path built when PRBS_ERRCNT_EN is defined.
module prbs5_checker #(
    parameter int LOCK_CNT   = 31,
    parameter int UNLOCK_ERR = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        din,
    input  logic        din_valid,
    input  logic        cnt_clr,
    output logic        locked,
    output logic        err,
`ifdef PRBS_ERRCNT_EN
    output logic [15:0] err_cnt,
`endif
    output logic [1:0]  state
);
    typedef enum logic [1:0] {
        FILL   = 2'd0,
        SEARCH = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t     r_state;
    logic [4:0] r_h;
    logic [2:0] r_fill_cnt;
    logic [5:0] r_match_cnt;
    logic [4:0] r_win_cnt;
    logic [4:0] r_win_err;
    logic       r_locked;
    logic       r_err;

    logic       w_pred;
    logic       w_mis;
    logic [4:0] w_h_din;
    logic [5:0] w_match_nx;
    logic [4:0] w_win_err_nx;
    logic       w_err_hit;

    assign w_pred       = r_h[1] ^ r_h[4];
    assign w_mis        = din ^ w_pred;
    assign w_h_din      = {r_h[3:0], din};
    // An all-zero history can only come from stuck-at-0 input, never a legal stream.
    assign w_match_nx   = (w_mis || (w_h_din == 5'd0)) ? 6'd0 : r_match_cnt + 6'd1;
    assign w_win_err_nx = r_win_err + {4'd0, w_mis};
    assign w_err_hit    = din_valid && (r_state == LOCKED) && w_mis;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= FILL;
            r_h         <= 5'd0;
            r_fill_cnt  <= 3'd0;
            r_match_cnt <= 6'd0;
            r_win_cnt   <= 5'd0;
            r_win_err   <= 5'd0;
            r_locked    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (din_valid) begin
                case (r_state)
                    FILL: begin
                        r_h        <= w_h_din;
                        r_fill_cnt <= r_fill_cnt + 3'd1;
                        if (r_fill_cnt == 3'd4) begin
                            r_state     <= SEARCH;
                            r_match_cnt <= 6'd0;
                        end
                    end
                    SEARCH: begin
                        r_h         <= w_h_din;
                        r_match_cnt <= w_match_nx;
                        if (w_match_nx == 6'(LOCK_CNT)) begin
                            r_state   <= LOCKED;
                            r_locked  <= 1'b1;
                            r_win_cnt <= 5'd0;
                            r_win_err <= 5'd0;
                        end
                    end
                    LOCKED: begin
                        // Free-run on the prediction so a single flipped bit costs one error only.
                        r_h   <= {r_h[3:0], w_pred};
                        r_err <= w_mis;
                        if (r_win_cnt == 5'd30) begin
                            r_win_cnt <= 5'd0;
                            r_win_err <= 5'd0;
                        end else begin
                            r_win_cnt <= r_win_cnt + 5'd1;
                            r_win_err <= w_win_err_nx;
                        end
                        if (w_win_err_nx == 5'(UNLOCK_ERR)) begin
                            r_state    <= FILL;
                            r_locked   <= 1'b0;
                            r_fill_cnt <= 3'd0;
                        end
                    end
                    default: begin
                        r_state    <= FILL;
                        r_locked   <= 1'b0;
                        r_fill_cnt <= 3'd0;
                    end
                endcase
            end
        end
    end

`ifdef PRBS_ERRCNT_EN
    logic [15:0] r_err_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_err_cnt <= 16'd0;
        end else if (cnt_clr) begin
            r_err_cnt <= {15'd0, w_err_hit};
        end else if (w_err_hit && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    logic w_unused_cnt;
    assign w_unused_cnt = cnt_clr ^ w_err_hit;
`endif

    assign locked = r_locked;
    assign err    = r_err;
    assign state  = r_state;
endmodule

// File: doc/prbs5_checker.md
# prbs5_checker

- Serial PRBS-5 receiver/checker; sits directly downstream of the team's 5-bit LFSR pattern generator.
- Consumes the generator's serial bit stream (generator bit 0 per step) and self-synchronises to the x^5+x^3+1 sequence (period 31).
- Flags bit errors once locked and reports lock status for board LEDs and bench scoreboards.

## Interface
- LOCK_CNT, 31: consecutive matching valid bits in SEARCH required to declare lock (1..63).
- UNLOCK_ERR, 4: errors within one 31-bit window in LOCKED that force loss of lock (1..31).
- clk  input  1  clock; all state updates on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- din  input  1  received serial bit.
- din_valid  input  1  din is sampled on rising clk when high; no state changes when low, except reset and cnt_clr.
- cnt_clr  input  1  synchronous clear of err_cnt.
- locked  output  1  high while in LOCKED.
- err  output  1  one-cycle pulse: last sampled bit mismatched while LOCKED.
- err_cnt  output  16  saturating error count. Present only with PRBS_ERRCNT_EN.
- state  output  2  FILL=0, SEARCH=1, LOCKED=2.

## Operation
- History register h[4:0]; h[0] is the most recent bit. Shifting a bit x gives {h[3:0],x}.
- Predicted bit p = h[1]^h[4], i.e. b[n] = b[n-2]^b[n-5].
- FILL:
  - Each valid bit shifts din into h and increments fill_cnt (0..5).
  - When fill_cnt reaches 5, go to SEARCH with match_cnt=0.
- SEARCH:
  - Each valid bit shifts din into h.
  - din==p: match_cnt+1. Otherwise match_cnt=0.
  - If the new h is all-zero, force match_cnt=0; a legal stream never has more than 4 consecutive zeros, so this rejects stuck-at-0 input.
  - When match_cnt reaches LOCK_CNT, go to LOCKED with win_cnt=0 and win_err=0.
- LOCKED:
  - Each valid bit shifts p (not din) into h, so the reference free-runs and one flipped bit gives exactly one err.
  - din!=p: err pulses and win_err increments.
  - win_cnt counts valid bits 0..30. On the bit where win_cnt==30, win_cnt wraps to 0 and win_err clears after that bit's error has been counted.
  - When win_err reaches UNLOCK_ERR, go to FILL with fill_cnt=0. The current bit's err still pulses.
- err_cnt (if compiled in):
  - Increments on each LOCKED error and saturates at 16'hFFFF.
  - cnt_clr with a simultaneous error loads 1; cnt_clr alone loads 0.
- Reset values: state=FILL, h=0, fill_cnt=0, match_cnt=0, win_cnt=0, win_err=0, locked=0, err=0, err_cnt=0.
- Reset mid-operation clears everything immediately; sync restarts from FILL.

## Timing
- All outputs are registered.
- err asserts in the cycle after the rising edge that sampled the bad bit, and lasts exactly one cycle.
- locked and state change in the cycle after the deciding bit is sampled.
- Lock latency from reset on a clean back-to-back stream: 5 + LOCK_CNT valid bits, so locked=1 after 36 edges at defaults.
- Unlock latency: the UNLOCK_ERR-th error within a window makes locked=0 one cycle after that bit is sampled.
- din_valid gaps stall all counters and h without loss of sync.

## Configuration
- PRBS_ERRCNT_EN defined: err_cnt register, saturation logic and cnt_clr path are built.
- Not defined: the err_cnt port is absent and cnt_clr is ignored. Lock/err behaviour is identical.

## Test plan
- Reset, then drive generator stream seeded 5'b10111 with din_valid=1 continuously -> state FILL→SEARCH after 5 bits, locked=1 exactly after bit 36, no err for 310 further bits.
- Locked, flip one bit -> exactly one err pulse, err_cnt=1, locked stays 1.
- Locked, flip 4 bits within one 31-bit window -> locked=0 the cycle after the 4th error, state=FILL. Flip 3 per window across 3 windows -> stays locked, err_cnt=9.
- Hold din=0 for 100 valid bits after reset -> never locks, state stays SEARCH. Drive din=1 constantly -> never locks.
- Random din_valid gaps (50%) on a clean stream -> locks after 36 valid bits, no err. Assert resetn low mid-LOCKED -> all outputs 0 immediately, relock after 36 valid bits.
- With PRBS_ERRCNT_EN: force err_cnt to 16'hFFFF and inject an error -> stays 16'hFFFF. cnt_clr together with an error -> 1. Without the macro: same lock/err results, no err_cnt port.
